// File: rtl/addsub_serial.sv
// Digit-serial two's-complement adder/subtractor: DIGIT bits per clock, LSB digit first,
// with a start/busy/done handshake and carry, signed-overflow and zero flags.
module addsub_serial #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StRun  = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("addsub_serial: WIDTH must be >= 2 and a multiple of DIGIT");
   end

   logic [1:0]       state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;
   logic             sub_q;
   logic             carry;
   logic [CW-1:0]    cnt;

   logic [DIGIT-1:0] a_dig;
   logic [DIGIT-1:0] b_dig;
   logic [DIGIT-1:0] s_dig;
   logic             c_next;
   logic             ovf_next;
   logic [WIDTH-1:0] res_next;

   always_comb begin
      a_dig           = a_sh[DIGIT-1:0];
      b_dig           = b_sh[DIGIT-1:0] ^ {DIGIT{sub_q}};
      {c_next, s_dig} = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry};
      // New digit enters at the top; after N shifts the LSB digit sits at bit 0.
      res_next                     = res_sh >> DIGIT;
      res_next[WIDTH-1 -: DIGIT]   = s_dig;
      // Only meaningful on the last digit, where the digit MSB is the word MSB.
      ovf_next = (a_dig[DIGIT-1] == b_dig[DIGIT-1]) && (s_dig[DIGIT-1] != a_dig[DIGIT-1]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= StIdle;
         a_sh   <= '0;
         b_sh   <= '0;
         res_sh <= '0;
         sub_q  <= 1'b0;
         carry  <= 1'b0;
         cnt    <= '0;
         result <= '0;
         cout   <= 1'b0;
         ovf    <= 1'b0;
         zero   <= 1'b0;
      end else begin
         case (state)
            StIdle, StDone: begin
               if (start) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  sub_q <= sub;
                  carry <= sub;
                  cnt   <= '0;
                  state <= StRun;
               end else begin
                  state <= StIdle;
               end
            end
            StRun: begin
               a_sh   <= a_sh >> DIGIT;
               b_sh   <= b_sh >> DIGIT;
               res_sh <= res_next;
               carry  <= c_next;
               cnt    <= cnt + 1'b1;
               if (cnt == LAST) begin
                  state  <= StDone;
                  result <= res_next;
                  cout   <= c_next;
                  ovf    <= ovf_next;
                  zero   <= ~|res_next;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

   assign busy = (state == StRun);
   assign done = (state == StDone);

endmodule

// File: tb/tb_addsub_serial.sv
// Self-checking bench for addsub_serial (WIDTH=8, DIGIT=2): directed vectors plus a
// cycle-level arithmetic model compared against the DUT on every cycle.
module tb_addsub_serial;

   localparam int W = 8;
   localparam int D = 2;
   localparam int N = W / D;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         sub = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         cout;
   logic         ovf;
   logic         zero;

   int passed = 0;
   int total  = 0;

   addsub_serial #(
      .WIDTH(W),
      .DIGIT(D)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .sub   (sub),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .result(result),
      .cout  (cout),
      .ovf   (ovf),
      .zero  (zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Behavioural model: operation counted in cycles, result from plain word arithmetic.
   int           run_left = 0;
   logic         m_done = 1'b0;
   logic [W-1:0] m_res = '0;
   logic         m_cout = 1'b0;
   logic         m_ovf = 1'b0;
   logic         m_zero = 1'b0;
   logic [W-1:0] p_res = '0;
   logic         p_cout = 1'b0;
   logic         p_ovf = 1'b0;

   always @(posedge clk) begin
      logic [W-1:0] bp;
      logic [W:0]   full;
      if (rst) begin
         run_left = 0;
         m_done   = 1'b0;
         m_res    = '0;
         m_cout   = 1'b0;
         m_ovf    = 1'b0;
         m_zero   = 1'b0;
      end else if (run_left > 0) begin
         run_left--;
         m_done = (run_left == 0);
         if (m_done) begin
            m_res  = p_res;
            m_cout = p_cout;
            m_ovf  = p_ovf;
            m_zero = (p_res == '0);
         end
      end else begin
         m_done = 1'b0;
         if (start) begin
            run_left = N;
            bp       = sub ? ~b : b;
            full     = {1'b0, a} + {1'b0, bp} + {{W{1'b0}}, sub};
            p_res    = full[W-1:0];
            p_cout   = full[W];
            p_ovf    = (a[W-1] == bp[W-1]) && (p_res[W-1] != a[W-1]);
         end
      end
   end

   always @(negedge clk) begin
      check("busy", {31'b0, busy}, {31'b0, run_left > 0});
      check("done", {31'b0, done}, {31'b0, m_done});
      check("result", {24'b0, result}, {24'b0, m_res});
      check("cout", {31'b0, cout}, {31'b0, m_cout});
      check("ovf", {31'b0, ovf}, {31'b0, m_ovf});
      check("zero", {31'b0, zero}, {31'b0, m_zero});
   end

   task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub,
                         input logic [W-1:0] er, input logic ec, input logic eo,
                         input logic ez, input bit poke);
      int lat;
      bit seen;
      lat  = 0;
      seen = 0;
      @(negedge clk);
      start = 1'b1;
      a     = ia;
      b     = ib;
      sub   = isub;
      for (int i = 1; i <= 20 && !seen; i++) begin
         @(negedge clk);
         if (i == 1) begin
            start = 1'b0;
            a     = 8'($urandom);
            b     = 8'($urandom);
            sub   = 1'($urandom);
         end
         if (poke && i == 2) begin
            start = 1'b1;
            a     = 8'hFF;
            b     = 8'h01;
            sub   = 1'b1;
         end
         if (poke && i == 3) start = 1'b0;
         if (done) begin
            seen = 1;
            lat  = i;
         end
      end
      check("latency", lat, N + 1);
      if (seen) begin
         check("lit_result", {24'b0, result}, {24'b0, er});
         check("lit_cout", {31'b0, cout}, {31'b0, ec});
         check("lit_ovf", {31'b0, ovf}, {31'b0, eo});
         check("lit_zero", {31'b0, zero}, {31'b0, ez});
         check("model_result", {24'b0, m_res}, {24'b0, er});
         check("model_cout", {31'b0, m_cout}, {31'b0, ec});
      end
   endtask

   initial begin
      int first;
      int second;
      first  = 0;
      second = 0;
      repeat (2) @(negedge clk);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_result", {24'b0, result}, 32'd0);
      check("rst_zero", {31'b0, zero}, 32'd0);
      rst = 1'b0;

      run_op(8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0, 0);
      run_op(8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0, 0);
      run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 0);
      run_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0, 0);
      run_op(8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 0);
      // Start during RUN with other operands must not disturb the operation.
      run_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0, 1);

      // Start held high through DONE: back-to-back operations.
      @(negedge clk);
      start = 1'b1;
      a     = 8'h40;
      b     = 8'h40;
      sub   = 1'b0;
      for (int i = 1; i <= 30 && second == 0; i++) begin
         @(negedge clk);
         if (first != 0 && i == first + 1) start = 1'b0;
         if (done) begin
            if (first == 0) begin
               first = i;
               check("b2b_result1", {24'b0, result}, 32'h80);
               check("b2b_ovf1", {31'b0, ovf}, 32'd1);
               a = 8'hC0;
               b = 8'h80;
            end else begin
               second = i;
               check("b2b_result2", {24'b0, result}, 32'h40);
               check("b2b_cout2", {31'b0, cout}, 32'd1);
               check("b2b_ovf2", {31'b0, ovf}, 32'd1);
            end
         end
      end
      start = 1'b0;
      check("b2b_first", first, N + 1);
      check("b2b_gap", second - first, N + 1);

      // Reset asserted during the second RUN cycle aborts the operation.
      @(negedge clk);
      start = 1'b1;
      a     = 8'h11;
      b     = 8'h22;
      sub   = 1'b0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("pre_rst_busy", {31'b0, busy}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", {31'b0, busy}, 32'd0);
      check("abort_done", {31'b0, done}, 32'd0);
      check("abort_result", {24'b0, result}, 32'd0);
      check("abort_cout", {31'b0, cout}, 32'd0);
      check("abort_ovf", {31'b0, ovf}, 32'd0);
      check("abort_zero", {31'b0, zero}, 32'd0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("abort_no_done", {31'b0, done}, 32'd0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule
